// File: rtl/pkt_hdr_capture_pkg.sv
// Shared definitions for the ingress header capture block and its
// egress-side reassembler counterpart.
package pkt_hdr_capture_pkg;

  localparam int SEG_WIDTH      = 256;
  localparam int NUM_SEGS       = 4;
  localparam int SEG_IDX_WIDTH  = $clog2(NUM_SEGS);
  localparam int KEEP_CNT_WIDTH = 6;
  localparam int HDR_LEN_WIDTH  = 8;

  // Header-record field offsets, shared with the reassembler.
  localparam int HDR_SEGS_OFF  = 0;
  localparam int HDR_LEN_OFF   = 1024;
  localparam int PKT_LEN_OFF   = 1032;
  localparam int HDR_TUSER_OFF = 1048;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } cap_state_t;

endpackage

// File: rtl/pkt_hdr_capture_keep_popcount.sv
// Combinational population count of a 32-bit AXIS tkeep; every set bit
// is one valid byte, contiguous or not.
module keep_popcount (
  input  logic [31:0] keep,
  output logic [5:0]  count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < 32; i++) begin
      count = count + {5'd0, keep[i]};
    end
  end

endmodule

// File: rtl/pkt_hdr_capture.sv
// Captures the first NUM_SEGS beats of an AXIS packet plus byte counts and
// first-beat tuser, and emits one header record per packet.
module pkt_hdr_capture
  import pkt_hdr_capture_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int PKT_LEN_WIDTH        = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [NUM_SEGS*SEG_WIDTH-1:0]     hdr_segs,
  output logic [HDR_LEN_WIDTH-1:0]          hdr_len,
  output logic [PKT_LEN_WIDTH-1:0]          pkt_len,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   hdr_tuser,
  output logic                              hdr_short,
  output logic                              hdr_valid,
  input  logic                              hdr_ready
);

  localparam int BEAT_IDX_WIDTH = SEG_IDX_WIDTH + 1;

  cap_state_t                            state, state_nxt;
  logic [NUM_SEGS-1:0][SEG_WIDTH-1:0]    work_segs, work_segs_nxt, out_segs;
  logic [HDR_LEN_WIDTH-1:0]              work_hdr_len, work_hdr_len_nxt;
  logic [PKT_LEN_WIDTH-1:0]              work_pkt_len, work_pkt_len_nxt;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]       work_tuser, work_tuser_nxt;
  logic [BEAT_IDX_WIDTH-1:0]             beat_idx, beat_idx_nxt;
  logic                                  publish, short_nxt, beat_acc;
  logic [KEEP_CNT_WIDTH-1:0]             keep_cnt;

  function automatic logic [PKT_LEN_WIDTH-1:0] sat_add(
    input logic [PKT_LEN_WIDTH-1:0]  a,
    input logic [KEEP_CNT_WIDTH-1:0] b
  );
    logic [PKT_LEN_WIDTH:0] sum;
    sum = {1'b0, a} + (PKT_LEN_WIDTH+1)'(b);
    return sum[PKT_LEN_WIDTH] ? '1 : sum[PKT_LEN_WIDTH-1:0];
  endfunction

  keep_popcount u_keep_popcount (
    .keep  (s_axis_tkeep),
    .count (keep_cnt)
  );

  // Input stalls only while a finished record is still waiting downstream.
  assign s_axis_tready = !(hdr_valid && !hdr_ready);
  assign beat_acc      = s_axis_tvalid && s_axis_tready;
  assign hdr_segs      = out_segs;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    work_segs_nxt    = work_segs;
    work_hdr_len_nxt = work_hdr_len;
    work_pkt_len_nxt = work_pkt_len;
    work_tuser_nxt   = work_tuser;
    beat_idx_nxt     = beat_idx;
    publish          = 1'b0;
    short_nxt        = 1'b0;
    if (beat_acc) begin
      case (state)
        IDLE: begin
          work_segs_nxt    = '0;
          work_segs_nxt[0] = s_axis_tdata;
          work_tuser_nxt   = s_axis_tuser;
          work_hdr_len_nxt = HDR_LEN_WIDTH'(keep_cnt);
          work_pkt_len_nxt = PKT_LEN_WIDTH'(keep_cnt);
          beat_idx_nxt     = BEAT_IDX_WIDTH'(1);
          if (s_axis_tlast) begin
            publish   = 1'b1;
            short_nxt = 1'b1;
          end else begin
            state_nxt = CAPTURE;
          end
        end
        CAPTURE: begin
          work_segs_nxt[beat_idx[SEG_IDX_WIDTH-1:0]] = s_axis_tdata;
          work_hdr_len_nxt = work_hdr_len + HDR_LEN_WIDTH'(keep_cnt);
          work_pkt_len_nxt = sat_add(work_pkt_len, keep_cnt);
          beat_idx_nxt     = beat_idx + 1'b1;
          if (s_axis_tlast) begin
            publish   = 1'b1;
            short_nxt = (beat_idx_nxt < BEAT_IDX_WIDTH'(NUM_SEGS));
            state_nxt = IDLE;
          end else if (beat_idx_nxt == BEAT_IDX_WIDTH'(NUM_SEGS)) begin
            state_nxt = DRAIN;
          end
        end
        DRAIN: begin
          work_pkt_len_nxt = sat_add(work_pkt_len, keep_cnt);
          if (s_axis_tlast) begin
            publish   = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work_segs    <= '0;
      work_hdr_len <= '0;
      work_pkt_len <= '0;
      work_tuser   <= '0;
      beat_idx     <= '0;
    end else begin
      work_segs    <= work_segs_nxt;
      work_hdr_len <= work_hdr_len_nxt;
      work_pkt_len <= work_pkt_len_nxt;
      work_tuser   <= work_tuser_nxt;
      beat_idx     <= beat_idx_nxt;
    end
  end

  // Publish wins over a same-edge handoff so back-to-back records need no bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_segs  <= '0;
      hdr_len   <= '0;
      pkt_len   <= '0;
      hdr_tuser <= '0;
      hdr_short <= 1'b0;
      hdr_valid <= 1'b0;
    end else if (publish) begin
      out_segs  <= work_segs_nxt;
      hdr_len   <= work_hdr_len_nxt;
      pkt_len   <= work_pkt_len_nxt;
      hdr_tuser <= work_tuser_nxt;
      hdr_short <= short_nxt;
      hdr_valid <= 1'b1;
    end else if (hdr_ready) begin
      hdr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pkt_hdr_capture.sv
// Directed bench for pkt_hdr_capture: a packet-level model checked every
// cycle plus hand-computed expectations for each scenario.
module tb_pkt_hdr_capture;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [255:0]  s_axis_tdata = '0;
  logic [31:0]   s_axis_tkeep = '0;
  logic [127:0]  s_axis_tuser = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic [1023:0] hdr_segs;
  logic [7:0]    hdr_len;
  logic [15:0]   pkt_len;
  logic [127:0]  hdr_tuser;
  logic          hdr_short;
  logic          hdr_valid;
  logic          hdr_ready = 1'b1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pkt_hdr_capture dut (
    .clk           (clk),
    .reset         (reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .hdr_segs      (hdr_segs),
    .hdr_len       (hdr_len),
    .pkt_len       (pkt_len),
    .hdr_tuser     (hdr_tuser),
    .hdr_short     (hdr_short),
    .hdr_valid     (hdr_valid),
    .hdr_ready     (hdr_ready)
  );

  task automatic checkOutput(input string name, input logic [255:0] actual,
                             input logic [255:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [255:0] mkData(input int p, input int b);
    logic [31:0] w;
    w = {16'(p), 16'(b)} ^ 32'h5A00_00C3;
    return {8{w}};
  endfunction

  function automatic logic [127:0] mkUser(input int p, input int b);
    logic [31:0] w;
    w = 32'(p * 1000 + b + 7);
    return {4{w}};
  endfunction

  // Packet-level model: a record is the first four beats, the byte sums
  // and the first tuser, handed over one clock after the tlast beat.
  logic         m_valid = 1'b0;
  logic [255:0] m_segs [4];
  int           m_hdr_len, m_pkt_len;
  logic [127:0] m_tuser;
  logic         m_short;
  logic [255:0] cur_segs [4];
  logic [127:0] cur_tuser;
  int           cur_count = 0, cur_bytes = 0, cur_hdr_bytes = 0;
  logic         acc, pub;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        m_valid   = 1'b0;
        cur_count = 0;
        checkOutput("reset_valid", 256'(hdr_valid), 256'(0));
        continue;
      end
      checkOutput("tready", 256'(s_axis_tready), 256'(!(m_valid && !hdr_ready)));
      checkOutput("hdr_valid", 256'(hdr_valid), 256'(m_valid));
      if (m_valid) begin
        for (int k = 0; k < 4; k++)
          checkOutput($sformatf("seg%0d", k), hdr_segs[k*256 +: 256], m_segs[k]);
        checkOutput("hdr_len", 256'(hdr_len), 256'(m_hdr_len));
        checkOutput("pkt_len", 256'(pkt_len), 256'(m_pkt_len));
        checkOutput("hdr_tuser", 256'(hdr_tuser), 256'(m_tuser));
        checkOutput("hdr_short", 256'(hdr_short), 256'(m_short));
      end
      acc = s_axis_tvalid && !(m_valid && !hdr_ready);
      pub = 1'b0;
      if (acc) begin
        if (cur_count == 0) begin
          for (int k = 0; k < 4; k++) cur_segs[k] = '0;
          cur_tuser     = s_axis_tuser;
          cur_bytes     = 0;
          cur_hdr_bytes = 0;
        end
        if (cur_count < 4) begin
          cur_segs[cur_count] = s_axis_tdata;
          cur_hdr_bytes += $countones(s_axis_tkeep);
        end
        cur_bytes += $countones(s_axis_tkeep);
        cur_count++;
        if (s_axis_tlast) begin
          for (int k = 0; k < 4; k++) m_segs[k] = cur_segs[k];
          m_hdr_len = cur_hdr_bytes;
          m_pkt_len = (cur_bytes > 65535) ? 65535 : cur_bytes;
          m_tuser   = cur_tuser;
          m_short   = (cur_count < 4);
          cur_count = 0;
          pub       = 1'b1;
        end
      end
      if (pub) m_valid = 1'b1;
      else if (hdr_ready) m_valid = 1'b0;
    end
  end

  task automatic applyStimulus(input logic [255:0] d, input logic [31:0] k,
                               input logic [127:0] u, input logic l);
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (s_axis_tready) begin
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    total++;
    bad++;
    $display("[TB] FAIL beat_timeout: got no accept after 100 cycles, required accept");
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid", 256'(hdr_valid), 256'(0));
    checkOutput("rst_len", 256'(hdr_len), 256'(0));
    checkOutput("rst_pkt_len", 256'(pkt_len), 256'(0));
    checkOutput("rst_seg0", hdr_segs[255:0], 256'(0));
    checkOutput("rst_tuser", 256'(hdr_tuser), 256'(0));
    checkOutput("rst_short", 256'(hdr_short), 256'(0));
    reset = 1'b0;
    idle(2);

    // 3-beat short packet: 32 + 32 + 8 bytes
    applyStimulus(mkData(1, 0), 32'hFFFF_FFFF, mkUser(1, 0), 1'b0);
    applyStimulus(mkData(1, 1), 32'hFFFF_FFFF, mkUser(1, 1), 1'b0);
    applyStimulus(mkData(1, 2), 32'h0000_00FF, mkUser(1, 2), 1'b1);
    checkOutput("t1_valid", 256'(hdr_valid), 256'(1));
    checkOutput("t1_len", 256'(hdr_len), 256'(72));
    checkOutput("t1_pkt_len", 256'(pkt_len), 256'(72));
    checkOutput("t1_seg3", hdr_segs[1023:768], 256'(0));
    checkOutput("t1_seg2", hdr_segs[767:512], mkData(1, 2));
    checkOutput("t1_short", 256'(hdr_short), 256'(1));
    idle(3);

    // 6 full beats, tuser differs per beat
    for (int b = 0; b < 6; b++)
      applyStimulus(mkData(2, b), 32'hFFFF_FFFF, mkUser(2, b), b == 5);
    checkOutput("t2_len", 256'(hdr_len), 256'(128));
    checkOutput("t2_pkt_len", 256'(pkt_len), 256'(192));
    checkOutput("t2_short", 256'(hdr_short), 256'(0));
    checkOutput("t2_tuser", 256'(hdr_tuser), 256'(mkUser(2, 0)));
    checkOutput("t2_seg0", hdr_segs[255:0], mkData(2, 0));
    checkOutput("t2_seg3", hdr_segs[1023:768], mkData(2, 3));
    idle(3);

    // exactly 4 beats, sparse keep on the last one
    for (int b = 0; b < 4; b++)
      applyStimulus(mkData(3, b), (b == 3) ? 32'hA5A5_0001 : 32'hFFFF_FFFF, mkUser(3, b), b == 3);
    checkOutput("t3_short", 256'(hdr_short), 256'(0));
    checkOutput("t3_len", 256'(hdr_len), 256'(105));
    checkOutput("t3_pkt_len", 256'(pkt_len), 256'(105));
    idle(3);

    // held record blocks the next packet until hdr_ready rises
    hdr_ready = 1'b0;
    applyStimulus(mkData(4, 0), 32'h0000_FFFF, mkUser(4, 0), 1'b1);
    s_axis_tdata  = mkData(5, 0);
    s_axis_tuser  = mkUser(5, 0);
    s_axis_tkeep  = 32'hFFFF_FFFF;
    s_axis_tlast  = 1'b1;
    s_axis_tvalid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t4_tready", 256'(s_axis_tready), 256'(0));
    checkOutput("t4_hold_valid", 256'(hdr_valid), 256'(1));
    checkOutput("t4_hold_tuser", 256'(hdr_tuser), 256'(mkUser(4, 0)));
    checkOutput("t4_hold_len", 256'(hdr_len), 256'(16));
    hdr_ready = 1'b1;
    applyStimulus(mkData(5, 0), 32'hFFFF_FFFF, mkUser(5, 0), 1'b1);
    checkOutput("t4_next_tuser", 256'(hdr_tuser), 256'(mkUser(5, 0)));
    checkOutput("t4_next_len", 256'(hdr_len), 256'(32));
    idle(3);

    // two 1-beat packets back to back
    applyStimulus(mkData(6, 0), 32'h0000_000F, mkUser(6, 0), 1'b1);
    checkOutput("t5_first_tuser", 256'(hdr_tuser), 256'(mkUser(6, 0)));
    checkOutput("t5_first_len", 256'(hdr_len), 256'(4));
    applyStimulus(mkData(7, 0), 32'h8000_0001, mkUser(7, 0), 1'b1);
    checkOutput("t5_second_valid", 256'(hdr_valid), 256'(1));
    checkOutput("t5_second_tuser", 256'(hdr_tuser), 256'(mkUser(7, 0)));
    checkOutput("t5_second_len", 256'(hdr_len), 256'(2));
    idle(3);

    // reset while a record is held clears outputs at once
    hdr_ready = 1'b0;
    applyStimulus(mkData(8, 0), 32'hFFFF_FFFF, mkUser(8, 0), 1'b1);
    #1 reset = 1'b1;
    #1;
    checkOutput("t6_held_valid", 256'(hdr_valid), 256'(0));
    checkOutput("t6_held_len", 256'(hdr_len), 256'(0));
    @(posedge clk); #1;
    reset     = 1'b0;
    hdr_ready = 1'b1;
    idle(2);

    // reset in the middle of a packet drops it
    applyStimulus(mkData(9, 0), 32'hFFFF_FFFF, mkUser(9, 0), 1'b0);
    applyStimulus(mkData(9, 1), 32'hFFFF_FFFF, mkUser(9, 1), 1'b0);
    s_axis_tdata = mkData(9, 2);
    #1 reset = 1'b1;
    #1;
    checkOutput("t6_cap_valid", 256'(hdr_valid), 256'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    idle(2);
    applyStimulus(mkData(10, 0), 32'hFFFF_FFFF, mkUser(10, 0), 1'b1);
    checkOutput("t6_clean_len", 256'(hdr_len), 256'(32));
    checkOutput("t6_clean_pkt_len", 256'(pkt_len), 256'(32));
    checkOutput("t6_clean_seg0", hdr_segs[255:0], mkData(10, 0));
    checkOutput("t6_clean_seg1", hdr_segs[511:256], 256'(0));
    checkOutput("t6_clean_tuser", 256'(hdr_tuser), 256'(mkUser(10, 0)));
    idle(3);

    // long packet: 2100 * 32 bytes saturates the byte counter
    for (int b = 0; b < 2100; b++)
      applyStimulus(mkData(11, b), 32'hFFFF_FFFF, mkUser(11, b), b == 2099);
    checkOutput("t7_pkt_len", 256'(pkt_len), 256'(16'hFFFF));
    checkOutput("t7_len", 256'(hdr_len), 256'(128));
    checkOutput("t7_short", 256'(hdr_short), 256'(0));
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
